// File: rtl/pipe_scroller.sv
// pipe_scroller: scrolls and recycles two pipes on Frame_Tick, scores passes of Bird_X, drives current-pipe edges, raw pipe positions, Score and Pass
module pipe_scroller #(
  parameter int SCREEN_W = 640,
  parameter int PIPE_W = 60,
  parameter int GAP_H = 120,
  parameter int GAP_MIN = 40,
  parameter int SPEED = 2,
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic Clk,
  input  logic reset,
  input  logic Frame_Tick,
  input  logic Start,
  input  logic Lose,
  input  logic Ack,
  input  logic [9:0] Bird_X,
  output logic [9:0] X_Edge_Left,
  output logic [9:0] X_Edge_Right,
  output logic [9:0] Y_Edge_Top,
  output logic [9:0] Y_Edge_Bottom,
  output logic [10:0] Pipe0_R,
  output logic [10:0] Pipe1_R,
  output logic [9:0] Pipe0_Gap,
  output logic [9:0] Pipe1_Gap,
  output logic [7:0] Score,
  output logic Pass
);
  localparam int SPACING = (SCREEN_W + PIPE_W) / 2;
  localparam logic [10:0] R0_INIT = 11'(SCREEN_W + PIPE_W);
  localparam logic [10:0] R1_INIT = 11'(SCREEN_W + PIPE_W + SPACING);
  localparam logic [10:0] SPD = 11'(SPEED);
  localparam logic [10:0] FWD = 11'(SPACING - SPEED);
  localparam logic [10:0] PW = 11'(PIPE_W);
  typedef enum logic [1:0] {IDLE, RUN, HALT} state_t;
  state_t state, state_n;
  logic [15:0] lfsr;
  logic [10:0] r0, r1, mv0, mv1, r_cur, mv_cur, left_raw, bird;
  logic [9:0] gap0, gap1, gap_cur, new_gap;
  logic cur, rc0, rc1, rc_cur, run_tick, start_go, ack_go, pass_n;
  assign new_gap = 10'(GAP_MIN) + {2'b0, lfsr[7:0]};
  assign bird = {1'b0, Bird_X};
  assign rc0 = r0 < SPD;
  assign rc1 = r1 < SPD;
  assign mv0 = rc0 ? r1 + FWD : r0 - SPD;
  assign mv1 = rc1 ? r0 + FWD : r1 - SPD;
  assign r_cur = cur ? r1 : r0;
  assign mv_cur = cur ? mv1 : mv0;
  assign rc_cur = cur ? rc1 : rc0;
  assign gap_cur = cur ? gap1 : gap0;
  assign run_tick = state == RUN && !Lose && Frame_Tick;
  assign start_go = state == IDLE && Start;
  assign ack_go = state == HALT && Ack;
  assign pass_n = run_tick && !rc_cur && r_cur >= bird && mv_cur < bird;
  always_comb begin
    state_n = state;
    state_n = start_go ? RUN : (state == RUN && Lose) ? HALT : ack_go ? IDLE : state;
  end
  always_ff @(posedge Clk or posedge reset)
    if (reset) begin
      state <= IDLE;
      lfsr <= SEED;
      r0 <= R0_INIT;
      r1 <= R1_INIT;
      gap0 <= 10'(GAP_MIN);
      gap1 <= 10'(GAP_MIN);
      cur <= 1'b0;
      Score <= '0;
      Pass <= 1'b0;
    end else begin
      state <= state_n;
      lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
      Pass <= pass_n;
      if (start_go) begin
        Score <= '0;
        cur <= 1'b0;
        gap0 <= new_gap;
        gap1 <= new_gap;
      end
      if (run_tick) begin
        r0 <= mv0;
        r1 <= mv1;
        if (rc0) gap0 <= new_gap;
        if (rc1) gap1 <= new_gap;
      end
      if (pass_n) begin
        cur <= ~cur;
        if (Score != 8'hFF) Score <= Score + 8'd1;
      end
      if (ack_go) begin
        r0 <= R0_INIT;
        r1 <= R1_INIT;
        cur <= 1'b0;
      end
    end
  assign left_raw = r_cur >= PW ? r_cur - PW : '0;
  assign X_Edge_Left = left_raw[10] ? 10'h3FF : left_raw[9:0];
  assign X_Edge_Right = r_cur[10] ? 10'h3FF : r_cur[9:0];
  assign Y_Edge_Top = gap_cur;
  assign Y_Edge_Bottom = gap_cur + 10'(GAP_H);
  assign Pipe0_R = r0;
  assign Pipe1_R = r1;
  assign Pipe0_Gap = gap0;
  assign Pipe1_Gap = gap1;
endmodule
